alu_datapath: RTL and testbench

Register/arithmetic datapath for the sequential 8-bit ALU: add, subtract, Booth radix-2 signed multiply and unsigned shift/subtract divide. Consumes the 15-bit one-hot control word produced by `control_unit` and returns the status flags (`q_0`, `q_min1`, `sign`, `cnt7`) that steer its state transitions. It has no FSM of its own: every cycle it executes the micro-operations selected by `c`.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/addsub_w1.sv | 21 ++
 rtl/alu_datapath.sv | 148 ++++++++++++++
 tb/tb_alu_datapath.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU datapath and its controller.
//   CW         width of the one-hot micro-operation word
//   C_*        bit index of each micro-operation inside that word
//   c_bit()    builds a word with a single micro-operation set
package alu_pkg;

    localparam int unsigned CW = 15;

    localparam int unsigned C_INIT_ADD = 0;   // A <= sext(X), Q/Q-1/CNT <= 0
    localparam int unsigned C_INIT_MUL = 1;   // A <= 0, Q <= X
    localparam int unsigned C_INIT_DIV = 2;   // A <= 0, Q <= X, div_mode set
    localparam int unsigned C_LOAD_M   = 3;   // M <= ext(Y)
    localparam int unsigned C_ADD      = 4;   // A <= A +/- M
    localparam int unsigned C_SUB      = 5;   // qualifier for C_ADD
    localparam int unsigned C_QBIT     = 6;   // Q[0] <= ~A[W]
    localparam int unsigned C_CNT      = 7;   // CNT++
    localparam int unsigned C_ASR      = 8;   // arithmetic shift right {A,Q,Q-1}
    localparam int unsigned C_SHL      = 9;   // logical shift left {A,Q}
    localparam int unsigned C_CNT2     = 10;  // CNT++ (mul loop)
    localparam int unsigned C_CORR     = 11;  // A <= A + M
    localparam int unsigned C_OUT_A    = 12;  // RESULT[hi] <= A[W-1:0]
    localparam int unsigned C_OUT_AQ   = 13;  // RESULT <= {A[W-1:0], Q}
    localparam int unsigned C_OUT_Q    = 14;  // RESULT[lo] <= Q

    function automatic logic [CW-1:0] c_bit(input int unsigned k);
        return CW'(1) << k;
    endfunction

endpackage

// File: rtl/addsub_w1.sv
// addsub_w1: combinational N-bit adder/subtractor, carry-out dropped.
//   a, b  operands
//   sub   1: s = a - b (a + ~b + 1), 0: s = a + b
//   s     result
module addsub_w1 #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s
);

    logic [N-1:0] w_b;

    always_comb begin
        w_b = sub ? ~b : b;
        s   = a + w_b + {{(N-1){1'b0}}, sub};
    end

endmodule

// File: rtl/alu_datapath.sv
// alu_datapath: register/arithmetic datapath of the sequential ALU (add, sub,
// Booth multiply, shift/subtract divide). Executes every cycle whatever
// micro-operations are set in c; it has no sequencing of its own.
//   clk, rst         clock, asynchronous active-low reset
//   c                one-hot micro-operation word
//   inbus_x/inbus_y  operands, sampled only on init / load-M edges
//   q_0, q_min1      Q[0], Q[-1]     (Booth decision bits)
//   sign             A[WIDTH]
//   cnt7             CNT == WIDTH-1  (pre-increment loop terminator)
//   result           result register
module alu_datapath
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CW-1:0]      c,
    input  logic [WIDTH-1:0]   inbus_x,
    input  logic [WIDTH-1:0]   inbus_y,
    output logic               q_0,
    output logic               q_min1,
    output logic               sign,
    output logic               cnt7,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH:0]     r_a;
    logic [WIDTH-1:0]   r_q;
    logic               r_qm1;
    logic [WIDTH:0]     r_m;
    logic [CntW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_div_mode;

    logic               w_init;
    logic               w_div_mode_next;
    logic               w_sub;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH-1:0]   w_q_next;
    logic [CntW-1:0]    w_cnt_inc;

    assign w_init = c[C_INIT_ADD] | c[C_INIT_MUL] | c[C_INIT_DIV];

    // M extension follows the init issued in the same cycle, if any.
    always_comb begin
        w_div_mode_next = r_div_mode;
        if (c[C_INIT_ADD] || c[C_INIT_MUL]) begin
            w_div_mode_next = 1'b0;
        end else if (c[C_INIT_DIV]) begin
            w_div_mode_next = 1'b1;
        end
        w_m_ext = w_div_mode_next ? {1'b0, inbus_y} : {inbus_y[WIDTH-1], inbus_y};
    end

    // Subtract only on the c4 path; the c11 correction always adds.
    assign w_sub = c[C_ADD] & c[C_SUB];

    addsub_w1 #(
        .N (WIDTH + 1)
    ) u_addsub (
        .a   (r_a),
        .b   (r_m),
        .sub (w_sub),
        .s   (w_sum)
    );

    always_comb begin
        w_q_next = r_q;
        if (c[C_INIT_ADD]) begin
            w_q_next = '0;
        end else if (c[C_INIT_MUL] || c[C_INIT_DIV]) begin
            w_q_next = inbus_x;
        end else if (c[C_ASR]) begin
            w_q_next = {r_a[0], r_q[WIDTH-1:1]};
        end else if (c[C_SHL]) begin
            w_q_next = {r_q[WIDTH-2:0], 1'b0};
        end
        // Quotient bit wins over a shift into Q[0].
        if (c[C_QBIT] && !w_init) begin
            w_q_next[0] = ~r_a[WIDTH];
        end
    end

    assign w_cnt_inc = (r_cnt == CntW'(WIDTH - 1)) ? '0 : r_cnt + CntW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a        <= '0;
            r_q        <= '0;
            r_qm1      <= 1'b0;
            r_m        <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_div_mode <= 1'b0;
        end else begin
            if (c[C_INIT_ADD]) begin
                r_a <= {inbus_x[WIDTH-1], inbus_x};
            end else if (c[C_INIT_MUL] || c[C_INIT_DIV]) begin
                r_a <= '0;
            end else if (c[C_ADD] || c[C_CORR]) begin
                r_a <= w_sum;
            end else if (c[C_ASR]) begin
                r_a <= {r_a[WIDTH], r_a[WIDTH:1]};
            end else if (c[C_SHL]) begin
                r_a <= {r_a[WIDTH-1:0], r_q[WIDTH-1]};
            end

            r_q <= w_q_next;

            if (w_init) begin
                r_qm1 <= 1'b0;
            end else if (c[C_ASR]) begin
                r_qm1 <= r_q[0];
            end

            if (w_init) begin
                r_cnt <= '0;
            end else if (c[C_CNT] || c[C_CNT2]) begin
                r_cnt <= w_cnt_inc;
            end

            r_div_mode <= w_div_mode_next;

            if (c[C_LOAD_M]) begin
                r_m <= w_m_ext;
            end

            if (c[C_OUT_A] || c[C_OUT_AQ]) begin
                r_result[2*WIDTH-1:WIDTH] <= r_a[WIDTH-1:0];
            end
            if (c[C_OUT_AQ] || c[C_OUT_Q]) begin
                r_result[WIDTH-1:0] <= r_q;
            end
        end
    end

    // Status depends on registers only, never on c.
    assign q_0    = r_q[0];
    assign q_min1 = r_qm1;
    assign sign   = r_a[WIDTH];
    assign cnt7   = (r_cnt == CntW'(WIDTH - 1));
    assign result = r_result;

endmodule

// File: tb/tb_alu_datapath.sv
module tb_alu_datapath;
    import alu_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] c;
    logic [7:0]    inbus_x;
    logic [7:0]    inbus_y;
    logic          q_0;
    logic          q_min1;
    logic          sign;
    logic          cnt7;
    logic [15:0]   result;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rx;
    logic [7:0]  ry;
    logic [15:0] saved;

    alu_datapath #(
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .c       (c),
        .inbus_x (inbus_x),
        .inbus_y (inbus_y),
        .q_0     (q_0),
        .q_min1  (q_min1),
        .sign    (sign),
        .cnt7    (cnt7),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One micro-operation cycle; outputs are stable 1 time unit after the edge.
    task automatic step(input logic [CW-1:0] w);
        c = w;
        @(posedge clk);
        #1;
        c = '0;
    endtask

    // Reference: sign-extended 9-bit sum/difference, upper result byte = low 8 bits.
    task automatic do_addsub(input logic [7:0] x, input logic [7:0] y, input bit sub,
                             input string tag);
        int s;
        s = sub ? ($signed(x) - $signed(y)) : ($signed(x) + $signed(y));
        inbus_x = x;
        inbus_y = y;
        step(c_bit(C_INIT_ADD));
        step(c_bit(C_LOAD_M));
        step(c_bit(C_ADD) | (sub ? c_bit(C_SUB) : '0));
        check({tag, "_sign"}, 32'(sign), 32'(s < 0));
        step(c_bit(C_OUT_A));
        check({tag, "_res"}, 32'(result[15:8]), 32'(s[7:0]));
    endtask

    // Reference: signed 8x8 product as 16 bits.
    task automatic do_mul(input logic [7:0] x, input logic [7:0] y, input string tag);
        int p;
        p = $signed(x) * $signed(y);
        inbus_x = x;
        inbus_y = y;
        step(c_bit(C_INIT_MUL));
        step(c_bit(C_LOAD_M));
        for (int i = 0; i < 8; i++) begin
            if ({q_0, q_min1} == 2'b10) step(c_bit(C_ADD) | c_bit(C_SUB));
            else if ({q_0, q_min1} == 2'b01) step(c_bit(C_ADD));
            step(c_bit(C_ASR));
            check($sformatf("%s_cnt7_%0d", tag, i), 32'(cnt7), 32'(i == 7));
            step(c_bit(C_CNT2));
        end
        step(c_bit(C_OUT_AQ));
        check({tag, "_prod"}, 32'(result), 32'(p[15:0]));
    endtask

    // Reference: unsigned quotient and remainder. Controller sequence is
    // non-restoring: shift, add or subtract by sign, quotient bit, count.
    task automatic do_div(input logic [7:0] x, input logic [7:0] y, input string tag);
        int unsigned q;
        int unsigned r;
        q = x / y;
        r = x % y;
        inbus_x = x;
        inbus_y = y;
        step(c_bit(C_INIT_DIV));
        step(c_bit(C_LOAD_M));
        for (int i = 0; i < 8; i++) begin
            step(c_bit(C_SHL));
            if (sign) step(c_bit(C_ADD));
            else step(c_bit(C_ADD) | c_bit(C_SUB));
            step(c_bit(C_QBIT));
            check($sformatf("%s_cnt7_%0d", tag, i), 32'(cnt7), 32'(i == 7));
            step(c_bit(C_CNT));
        end
        if (sign) step(c_bit(C_CORR));
        step(c_bit(C_OUT_A));
        step(c_bit(C_OUT_Q));
        check({tag, "_qr"}, 32'(result), {16'h0, r[7:0], q[7:0]});
    endtask

    initial begin
        // Reset held low while c toggles randomly.
        rst     = 1'b0;
        inbus_x = 8'($urandom);
        inbus_y = 8'($urandom);
        c       = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            c = CW'($urandom);
        end
        c = '0;
        #1;
        rst = 1'b1;
        #1;
        check("rst_flags", {28'h0, q_0, q_min1, sign, cnt7}, 32'h0);
        check("rst_result", 32'(result), 32'h0);

        // Counter wrap: cnt7 only after the 7th pulse, then wraps.
        for (int k = 1; k <= 9; k++) begin
            step(c_bit(C_CNT));
            check($sformatf("cnt_k%0d", k), 32'(cnt7), 32'(k == 7));
        end
        for (int k = 0; k < 6; k++) step(c_bit(C_CNT2));
        check("cnt_after_wrap", 32'(cnt7), 32'h1);

        // Directed operations.
        do_addsub(8'h25, 8'h13, 1'b0, "add");
        do_addsub(8'h25, 8'h13, 1'b1, "sub");
        do_mul(8'hFD, 8'h07, "mul");
        do_div(8'h64, 8'h07, "div");
        do_mul(8'h80, 8'h80, "mul_min");
        do_div(8'hFF, 8'h01, "div_one");

        // Randomized operations.
        for (int n = 0; n < 4; n++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            do_addsub(rx, ry, n[0], $sformatf("radd%0d", n));
            rx = 8'($urandom);
            ry = 8'($urandom);
            do_mul(rx, ry, $sformatf("rmul%0d", n));
            rx = 8'($urandom);
            ry = 8'($urandom_range(127, 1));
            do_div(rx, ry, $sformatf("rdiv%0d", n));
        end

        // Idle and lone c5 must hold state.
        do_mul(8'h0B, 8'hF3, "mul_hold");
        saved = result;
        step('0);
        step(c_bit(C_SUB));
        step('0);
        check("hold_result", 32'(result), 32'(saved));

        // Conflict: init_mul with add -> A cleared, Q loaded from X.
        do_addsub(8'h7F, 8'h40, 1'b0, "pre_conf");
        inbus_x = 8'hA5;
        step(c_bit(C_INIT_MUL) | c_bit(C_ADD));
        check("conf_sign", 32'(sign), 32'h0);
        check("conf_q0", 32'(q_0), 32'h1);
        step(c_bit(C_OUT_AQ));
        check("conf_aq", 32'(result), 32'h00A5);

        // Asynchronous reset mid-operation: cleared without a clock edge.
        do_addsub(8'h80, 8'h80, 1'b0, "pre_rst");
        step(c_bit(C_INIT_ADD));
        step(c_bit(C_ADD));
        check("pre_rst_sign", 32'(sign), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_sign", 32'(sign), 32'h0);
        check("async_rst_result", 32'(result), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
